// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic-unit arbiter: opcode encodings, opcode
// width and the arbiter FSM state type.
package logic_unit_arbiter_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_NAND = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/logic_unit.sv
// Combinational six-function bitwise logic unit (three-input gates).
// Ports:
//   a, b, c : W-bit operands
//   op      : opcode (AND, NAND, OR, NOR, XOR, XNOR; 6 and 7 illegal)
//   y       : W-bit result, zero for an illegal opcode
//   err     : high for an illegal opcode
module logic_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [W-1:0]    c,
  input  logic [OP_W-1:0] op,
  output logic [W-1:0]    y,
  output logic            err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b & c;
      OP_NAND: y = ~(a & b & c);
      OP_OR:   y = a | b | c;
      OP_NOR:  y = ~(a | b | c);
      OP_XOR:  y = a ^ b ^ c;
      OP_XNOR: y = ~(a ^ b ^ c);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of a single shared logic unit. One request is
// accepted at a time: IDLE grants and captures operands, EXEC computes, RESP
// holds the result until the consumer takes it.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req [N]              : per-requester request, held until granted
//   op [3N], a/b/c [WN]  : per-requester opcode and operands
//   gnt [N]              : one-hot, one-cycle grant pulse
//   res_valid/res_ready  : result handshake
//   res_id, res, res_err : owner index, result, illegal-opcode flag
//   busy                 : high whenever not in IDLE
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [OP_W*N-1:0]    op,
  input  logic [W*N-1:0]       a,
  input  logic [W*N-1:0]       b,
  input  logic [W*N-1:0]       c,
  output logic [N-1:0]         gnt,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [$clog2(N)-1:0] res_id,
  output logic [W-1:0]         res,
  output logic                 res_err,
  output logic                 busy
);

  localparam int unsigned IW = $clog2(N);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win;
  logic            found;

  logic [OP_W-1:0] op_sel, op_q, op_d;
  logic [W-1:0]    a_sel, a_q, a_d;
  logic [W-1:0]    b_sel, b_q, b_d;
  logic [W-1:0]    c_sel, c_q, c_d;
  logic [IW-1:0]   id_q, id_d;

  logic [N-1:0]    gnt_q, gnt_d;
  logic            res_valid_q, res_valid_d;
  logic [W-1:0]    res_q, res_d;
  logic            res_err_q, res_err_d;
  logic [IW-1:0]   res_id_q, res_id_d;
  logic            busy_q, busy_d;

  logic [W-1:0]    lu_y;
  logic            lu_err;

  // Round-robin search from ptr upward; IW-bit addition wraps since N is 2^IW.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req[ptr_q + IW'(k)]) begin
        found = 1'b1;
        win   = ptr_q + IW'(k);
      end
    end
  end

  // Operand slice of the current winner.
  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    c_sel  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win == IW'(i)) begin
        op_sel = op[OP_W*i +: OP_W];
        a_sel  = a[W*i +: W];
        b_sel  = b[W*i +: W];
        c_sel  = c[W*i +: W];
      end
    end
  end

  logic_unit #(.W(W)) u_logic_unit (
    .a   (a_q),
    .b   (b_q),
    .c   (c_q),
    .op  (op_q),
    .y   (lu_y),
    .err (lu_err)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    id_d     = id_q;
    gnt_d    = '0;
    res_d    = res_q;
    res_err_d = res_err_q;
    res_id_d = res_id_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = EXEC;
          gnt_d[win] = 1'b1;
          ptr_d      = win + IW'(1);
          op_d       = op_sel;
          a_d        = a_sel;
          b_d        = b_sel;
          c_d        = c_sel;
          id_d       = win;
        end
      end
      EXEC: begin
        state_d   = RESP;
        res_d     = lu_y;
        res_err_d = lu_err;
        res_id_d  = id_q;
      end
      RESP: begin
        if (res_ready) begin
          state_d   = IDLE;
          res_d     = '0;
          res_err_d = 1'b0;
          res_id_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    res_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      res_err_q   <= 1'b0;
      res_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      id_q        <= id_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      res_err_q   <= res_err_d;
      res_id_q    <= res_id_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign res       = res_q;
  assign res_err   = res_err_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters; the value SHALL be a power of two, 2..8.
REQ-002 Parameter W, default 8: operand and result width in bits; all gate functions SHALL be bitwise.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  N  per-requester request; SHALL be held until the matching gnt bit is seen high.
REQ-006 op  input  3*N  per-requester opcode; slice i is op[3i+2:3i].
REQ-007 a, b, c  input  W*N each  per-requester operands; slice i is [W*i+W-1:W*i].
REQ-008 gnt  output  N  one-hot grant, a one-cycle pulse.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer accepts the result.
REQ-011 res_id  output  log2(N)  index of the requester that owns res.
REQ-012 res  output  W  result.
REQ-013 res_err  output  1  the opcode was illegal.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Opcodes SHALL be: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR; each SHALL be a three-input function of a, b and c.
REQ-016 Opcodes 6 and 7 SHALL produce res=0 with res_err=1; every legal opcode SHALL produce res_err=0.
REQ-017 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-018 IDLE with no req bit set SHALL remain in IDLE.
REQ-019 IDLE with any req bit set SHALL, at the next edge:
- select a winner round-robin, searching from pointer ptr upward and wrapping;
- register the winner's op, a, b, c and index;
- drive gnt one-hot to the winner for exactly one cycle;
- go to EXEC.
REQ-020 EXEC SHALL compute on the captured operands, register res, res_err and res_id, and go to RESP at the next edge.
REQ-021 RESP SHALL hold res_valid=1 with res, res_id and res_err stable until an edge at which res_ready=1; it SHALL then go to IDLE.
REQ-022 The latency from a req first seen in IDLE at cycle t SHALL be: gnt at t+1, res_valid at t+2.
REQ-023 The minimum spacing between successive grants SHALL be 3 cycles, with res_ready held at 1.
REQ-024 On each grant, ptr SHALL become (winner+1) mod N.
REQ-025 req SHALL be ignored in EXEC and RESP; operands changing after the capture edge SHALL NOT affect res.
REQ-026 If the granted requester still holds req in the gnt cycle, that SHALL NOT be treated as a new request, because the arbiter is in EXEC during that cycle.
REQ-027 res_ready=1 outside RESP SHALL have no effect.
REQ-028 res SHALL be 0 whenever res_valid=0.

Reset
REQ-029 On rst=1 at an edge, the block SHALL enter IDLE with ptr=0, gnt=0, res_valid=0, res=0, res_id=0, res_err=0 and busy=0.
REQ-030 rst SHALL take priority over every transition; a reset in EXEC or RESP SHALL discard the in-flight result, and no res_valid SHALL follow it.
REQ-031 The first arbitration after reset SHALL start its search at requester 0.

Structure
REQ-032 A shared package SHALL hold the opcode constants (OP_AND..OP_XNOR), the FSM state typedef and the opcode width constant (3).
REQ-033 The combinational six-function unit SHALL be a separate sub-module, logic_unit (inputs a, b, c, op; outputs y, err), instantiated once.
REQ-034 The arbiter and FSM SHALL reside in logic_unit_arbiter; no other sub-modules are required.

Verification
REQ-035 Single request: N=4, W=8, req=0010, op1=4, a=F0, b=CC, c=AA, res_ready=1 -> gnt=0010 at t+1; res_valid=1, res_id=1, res=96, res_err=0 at t+2; IDLE at t+3.
REQ-036 Round-robin, all requesters: req=1111 held, each dropped after its grant -> grant order 0,1,2,3; each grant at least 3 cycles after the previous; ptr wraps to 0.
REQ-037 Fairness: after granting 2, req=0101 -> 0 is skipped in favour of... no, search starts at 3, so 0 is granted next, then 2.
REQ-038 Backpressure: res_ready=0 for 5 cycles in RESP, operands changed meanwhile -> res, res_id and res_valid stable throughout; exit on the first edge with res_ready=1.
REQ-039 Illegal opcode: op=7, a=b=c=FF -> res=00 and res_err=1; a following op=1 with a=b=c=FF -> res=00 and res_err=0.
REQ-040 Reset mid-operation: rst=1 during EXEC -> the next cycle shows IDLE with all outputs 0, no res_valid pulse, and the next grant goes to requester 0.
